// File: rtl/mips_pkg.sv
// Shared definitions for the memory-side blocks: default bus widths and the
// encoding used to tag in-flight memory responses.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int MEM_AW     = 14;
  localparam int STARVE_DEF = 3;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_I    = 2'd1,
    SRC_D    = 2'd2
  } rsp_src_e;

  // First response stage: who owns the RAM read, plus the D-side error tag.
  typedef struct packed {
    rsp_src_e src;
    logic     we;
    logic     err;
  } rsp_stage_t;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and shared-RAM signals of the memory arbiter, bundled so the
// arbiter (slave) and its surroundings (master) see complementary directions.
interface mem_arbiter_if
  import mips_pkg::*;
#(
  parameter int WIDTH    = DATA_W,
  parameter int MEMDEPTH = MEM_AW
);

  logic                i_req;
  logic [WIDTH-1:0]    i_addr;
  logic                i_gnt;
  logic                i_valid;
  logic [WIDTH-1:0]    i_rdata;

  logic                d_req;
  logic                d_we;
  logic [WIDTH-1:0]    d_addr;
  logic [WIDTH-1:0]    d_wdata;
  logic                d_gnt;
  logic                d_valid;
  logic [WIDTH-1:0]    d_rdata;
  logic                d_err;

  logic                mem_en;
  logic                mem_we;
  logic [MEMDEPTH-1:0] mem_addr;
  logic [WIDTH-1:0]    mem_wdata;
  logic [WIDTH-1:0]    mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/arb_starve_cnt.sv
// Counts consecutive cycles the fetch side has been refused; once it reaches
// STARVE_MAX the fetch side is flagged to win the next arbitration.
module arb_starve_cnt #(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic gnt_i,
  output logic starve_o
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign starve_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/flopr.sv
// Plain register with synchronous active-high reset to zero.
module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (rst) q_o <= '0;
    else     q_o <= d_i;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one single-port synchronous RAM,
// D-priority with a starvation override, and returns responses two cycles later.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int WIDTH      = DATA_W,
  parameter int MEMDEPTH   = MEM_AW,
  parameter int STARVE_MAX = STARVE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  mem_arbiter_if.slave    bus
);

  logic                i_req;
  logic [WIDTH-1:0]    i_addr;
  logic                d_req;
  logic                d_we;
  logic [WIDTH-1:0]    d_addr;
  logic [WIDTH-1:0]    d_wdata;
  logic [WIDTH-1:0]    mem_rdata;

  logic                starve;
  logic                d_mis;
  logic                i_gnt;
  logic                d_gnt;
  logic                mem_en;
  logic                mem_we;
  logic [MEMDEPTH-1:0] mem_addr;
  logic [WIDTH-1:0]    mem_wdata;

  rsp_stage_t          s1_d;
  rsp_stage_t          s1_q;
  logic [2:0]          vld_d;
  logic [2:0]          vld_q;
  logic [WIDTH-1:0]    i_rdata_d;
  logic [WIDTH-1:0]    i_rdata_q;
  logic [WIDTH-1:0]    d_rdata_d;
  logic [WIDTH-1:0]    d_rdata_q;

  logic                unused_addr_bits;

  assign i_req     = bus.i_req;
  assign i_addr    = bus.i_addr;
  assign d_req     = bus.d_req;
  assign d_we      = bus.d_we;
  assign d_addr    = bus.d_addr;
  assign d_wdata   = bus.d_wdata;
  assign mem_rdata = bus.mem_rdata;

  // Only the word-address window reaches the RAM; fetch byte offset is ignored.
  assign unused_addr_bits = ^{i_addr[1:0], i_addr[WIDTH-1:MEMDEPTH+2],
                              d_addr[WIDTH-1:MEMDEPTH+2]};

  assign d_mis = d_req && is_misaligned(d_addr[1:0]);

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .req_i    (i_req),
    .gnt_i    (i_gnt),
    .starve_o (starve)
  );

  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      // A misaligned data access never touches the RAM, so fetch rides along.
      if (d_mis) begin
        d_gnt = 1'b1;
        i_gnt = i_req;
      end else if (d_req && i_req) begin
        i_gnt = starve;
        d_gnt = !starve;
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end

      if (i_gnt) begin
        mem_en   = 1'b1;
        mem_addr = i_addr[MEMDEPTH+1:2];
      end else if (d_gnt && !d_mis) begin
        mem_en   = 1'b1;
        mem_we   = d_we;
        mem_addr = d_addr[MEMDEPTH+1:2];
        if (d_we) mem_wdata = d_wdata;
      end
    end
  end

  always_comb begin
    s1_d = '{src: SRC_NONE, we: 1'b0, err: 1'b0};
    if (i_gnt) begin
      s1_d.src = SRC_I;
    end else if (d_gnt && !d_mis) begin
      s1_d.src = SRC_D;
      s1_d.we  = d_we;
    end
    s1_d.err = d_gnt && d_mis;
  end

  flopr #(.WIDTH($bits(rsp_stage_t))) u_stage1 (
    .clk (clk),
    .rst (rst),
    .d_i (s1_d),
    .q_o (s1_q)
  );

  // Stage 2 captures RAM data in N+1 and raises the valid pulses for N+2.
  assign vld_d = {s1_q.src == SRC_I,
                  (s1_q.src == SRC_D) || s1_q.err,
                  s1_q.err};

  assign i_rdata_d = (s1_q.src == SRC_I) ? mem_rdata : i_rdata_q;
  assign d_rdata_d = (s1_q.src == SRC_D && !s1_q.we) ? mem_rdata : d_rdata_q;

  flopr #(.WIDTH(3)) u_stage2_vld (
    .clk (clk),
    .rst (rst),
    .d_i (vld_d),
    .q_o (vld_q)
  );

  flopr #(.WIDTH(WIDTH)) u_stage2_irdata (
    .clk (clk),
    .rst (rst),
    .d_i (i_rdata_d),
    .q_o (i_rdata_q)
  );

  flopr #(.WIDTH(WIDTH)) u_stage2_drdata (
    .clk (clk),
    .rst (rst),
    .d_i (d_rdata_d),
    .q_o (d_rdata_q)
  );

  assign bus.i_gnt     = i_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.i_valid   = vld_q[2];
  assign bus.d_valid   = vld_q[1];
  assign bus.d_err     = vld_q[0];
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule
